// File: rtl/line_fetch_pkg.sv
// line_fetch_pkg: Wishbone cycle-type codes and FSM states shared by the line refill master.
package line_fetch_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END = 3'b111;
    localparam logic [1:0] BTE_LINEAR = 2'b00;
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
endpackage

// File: rtl/line_fetch_buf.sv
// line_fetch_buf: line storage written one word per beat, read out as one flat vector.
module line_fetch_buf #(
    parameter int WORDS = 8,
    parameter int WORD_BITS = 32,
    parameter int IDX_BITS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [IDX_BITS-1:0]        idx,
    input  logic [WORD_BITS-1:0]       wdata,
    output logic [WORDS*WORD_BITS-1:0] line
);
    logic [WORDS-1:0][WORD_BITS-1:0] mem;
    always_ff @(posedge clk)
        for (int i = 0; i < WORDS; i++)
            if (rst) mem[i] <= '0;
            else if (we && idx == IDX_BITS'(i)) mem[i] <= wdata;
    assign line = mem;
endmodule

// File: rtl/line_fetch.sv
// line_fetch: Wishbone master refilling one cache line with a linear incrementing burst.
// Define LINE_FETCH_TIMEOUT_EN to abort a beat after TIMEOUT cycles without ack/err.
module line_fetch
    import line_fetch_pkg::*;
#(
    parameter int WB_ADDR_BITS = 32,
    parameter int WORD_BYTES = 4,
    parameter int LINE_WORDS_BITS = 3,
    parameter int TIMEOUT = 255,
    localparam int WORD_BITS = 8 * WORD_BYTES,
    localparam int AW = WB_ADDR_BITS - 2
) (
    input  logic                                   wbm_clk_i,
    input  logic                                   wbm_rst_i,
    input  logic                                   req_i,
    input  logic [AW-1:0]                          req_addr_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   err_o,
    output logic [(WORD_BITS<<LINE_WORDS_BITS)-1:0] line_o,
    output logic                                   wbm_cyc_o,
    output logic                                   wbm_stb_o,
    output logic                                   wbm_we_o,
    output logic [WORD_BYTES-1:0]                  wbm_sel_o,
    output logic [AW-1:0]                          wbm_addr_o,
    output logic [2:0]                             wbm_cti_o,
    output logic [1:0]                             wbm_bte_o,
    input  logic [WORD_BITS-1:0]                   wbm_data_i,
    input  logic                                   wbm_ack_i,
    input  logic                                   wbm_err_i
);
    localparam int WORDS = 1 << LINE_WORDS_BITS;
    localparam int CW = LINE_WORDS_BITS > 0 ? LINE_WORDS_BITS : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
    state_t state;
    logic [CW-1:0] count;
    logic timeout, abort, beat;
    assign wbm_we_o = 1'b0;
    assign wbm_sel_o = '1;
    assign wbm_bte_o = BTE_LINEAR;
    assign abort = state == BURST && (wbm_err_i || timeout);
    assign beat = state == BURST && wbm_ack_i && !abort;
`ifdef LINE_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    assign timeout = !wbm_ack_i && wait_cnt == TW'(TIMEOUT - 1);
    always_ff @(posedge wbm_clk_i)
        wait_cnt <= wbm_rst_i || state != BURST || wbm_ack_i ? '0 : wait_cnt + 1'b1;
`else
    assign timeout = 1'b0;
`endif
    // The address never carries out of the line: it only increments while count < LAST.
    always_ff @(posedge wbm_clk_i)
        if (wbm_rst_i) begin
            state <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            err_o <= 1'b0;
            wbm_cti_o <= CTI_CLASSIC;
            wbm_addr_o <= '0;
            count <= '0;
        end else begin
            done_o <= 1'b0;
            err_o <= 1'b0;
            if (state == IDLE) begin
                if (req_i) begin
                    state <= BURST;
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    busy_o <= 1'b1;
                    wbm_addr_o <= req_addr_i & ~AW'(WORDS - 1);
                    count <= '0;
                    wbm_cti_o <= LINE_WORDS_BITS == 0 ? CTI_END : CTI_INCR;
                end
            end else if (abort || (beat && wbm_cti_o == CTI_END)) begin
                state <= IDLE;
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                busy_o <= 1'b0;
                wbm_cti_o <= CTI_CLASSIC;
                count <= '0;
                done_o <= !abort;
                err_o <= abort;
            end else if (beat) begin
                wbm_addr_o <= wbm_addr_o + 1'b1;
                count <= count + 1'b1;
                wbm_cti_o <= count + 1'b1 == LAST ? CTI_END : CTI_INCR;
            end
        end
    line_fetch_buf #(.WORDS(WORDS), .WORD_BITS(WORD_BITS), .IDX_BITS(CW)) u_buf (
        .clk(wbm_clk_i),
        .rst(wbm_rst_i),
        .we(beat),
        .idx(count),
        .wdata(wbm_data_i),
        .line(line_o)
    );
endmodule

// File: tb/tb_line_fetch.sv
// tb_line_fetch: randomized line refills against a Wishbone slave model and a line scoreboard.
module tb_line_fetch;
    localparam int WORDS = 8;
    localparam int WB = 32;
    localparam int LW = WB * WORDS;
    localparam int TMO = 16;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, ack = 1'b0, werr = 1'b0;
    logic [29:0] req_addr = '0;
    logic [WB-1:0] data = '0;
    logic busy, done, perr, cyc, stb, we;
    logic [LW-1:0] line;
    logic [3:0] sel;
    logic [29:0] addr;
    logic [2:0] cti;
    logic [1:0] bte;
    line_fetch #(.TIMEOUT(TMO)) dut (
        .wbm_clk_i(clk), .wbm_rst_i(rst), .req_i(req), .req_addr_i(req_addr),
        .busy_o(busy), .done_o(done), .err_o(perr), .line_o(line),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_addr_o(addr), .wbm_cti_o(cti), .wbm_bte_o(bte),
        .wbm_data_i(data), .wbm_ack_i(ack), .wbm_err_i(werr)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic is_err;
        logic [LW-1:0] line;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [LW-1:0] ref_line = '0;
    logic [31:0] key;
    int n_cmp = 0, n_bad = 0;

    function automatic logic [WB-1:0] mem_word(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E3779B1) ^ key;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done/err pulse retires the oldest expected outcome.
    always @(negedge clk)
        if (done || perr) begin
            if (sb.size() == 0) chk("unexpected_pulse", {done, perr}, 0);
            else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", {done, perr}, mon_e.is_err ? 2'b01 : 2'b10);
                chk("line", line, mon_e.line);
            end
        end

    task automatic run_fetch(input logic [29:0] a, input int waits, input int err_beat,
                             input int rst_beat, input bit noise);
        logic [29:0] base;
        logic [LW-1:0] nl;
        exp_t e;
        int beat, w, cyc_n;
        base = a & ~30'(WORDS - 1);
        nl = ref_line;
        beat = 0;
        w = 0;
        cyc_n = 0;
        req = 1'b1;
        req_addr = a;
        @(negedge clk);
        req = noise;
        req_addr = ~a;
        chk("start", {busy, cyc, stb}, 3'b111);
        chk("consts", {we, sel, bte}, 7'b0111100);
        if (rst_beat < 0) begin
            for (int i = 0; i < WORDS; i++)
                if (err_beat < 0 || i < err_beat) nl[i*WB +: WB] = mem_word(base + 30'(i));
            e.is_err = err_beat >= 0;
            e.line = nl;
            sb.push_back(e);
            ref_line = nl;
        end
        while (cyc && cyc_n <= 400) begin
            chk("addr", addr, base + 30'(beat));
            chk("cti", cti, beat == WORDS - 1 ? 3'b111 : 3'b010);
            if (beat == rst_beat) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                req = 1'b0;
                chk("rst_outs", {cyc, stb, busy, done, perr}, 0);
                chk("rst_line", line, 0);
                ref_line = '0;
                return;
            end
            if (w < waits) w++;
            else if (beat == err_beat) werr = 1'b1;
            else begin
                ack = 1'b1;
                data = mem_word(addr);
                w = 0;
                beat++;
            end
            @(negedge clk);
            ack = 1'b0;
            werr = 1'b0;
            cyc_n++;
        end
        req = 1'b0;
        if (cyc_n > 400) begin
            chk("burst_bound", cyc_n, 0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
            ref_line = '0;
            return;
        end
        chk("end_pulse", {done, perr}, err_beat >= 0 ? 2'b01 : 2'b10);
        chk("end_busy", {busy, cyc, stb}, 0);
        chk("beats", beat, err_beat >= 0 ? err_beat : WORDS);
        if (noise) begin
            @(negedge clk);
            chk("ignored_req", busy, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waits, eb;
        key = $urandom;
        repeat (3) @(negedge clk);
        chk("reset_outs", {cyc, stb, busy, done, perr, cti, addr}, 0);
        chk("reset_line", line, 0);
        rst = 1'b0;
        @(negedge clk);
        run_fetch(30'h10, 0, -1, -1, 1'b0);
        run_fetch(30'h13, 0, -1, -1, 1'b0);
        run_fetch(30'h13, 2, -1, -1, 1'b0);
        run_fetch(30'h28, 0, 3, -1, 1'b0);
        run_fetch(30'h30, 1, -1, 5, 1'b0);
        run_fetch(30'h10, 0, -1, -1, 1'b1);
        for (int k = 0; k < 25; k++) begin
            waits = int'($urandom_range(0, 2));
            eb = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, WORDS - 1)) : -1;
            run_fetch(30'($urandom), waits, eb, -1, 1'($urandom_range(0, 1)));
        end
`ifdef LINE_FETCH_TIMEOUT_EN
        begin
            int n;
            exp_t e;
            n = 0;
            req = 1'b1;
            req_addr = 30'h50;
            @(negedge clk);
            req = 1'b0;
            e.is_err = 1'b1;
            e.line = ref_line;
            sb.push_back(e);
            while (!perr && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_cycles", n, TMO);
        end
`endif
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("line_hold", line, ref_line);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
